// File: rtl/sgd_x_rd_if.sv
// Bus bundle for sgd_x_rd: x BRAM read port plus the chunk stream toward the ax pipeline.
// master = the reader block, slave = BRAM/ax side.
interface sgd_x_rd_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 256
);
  logic                  x_rd_en;
  logic [ADDR_WIDTH-1:0] x_rd_addr;
  logic [DATA_WIDTH-1:0] x_rd_data;
  logic                  x_out_valid;
  logic                  x_out_ready;
  logic [DATA_WIDTH-1:0] x_out_data;
  logic                  x_out_first;
  logic                  x_out_last;

  modport master (
    output x_rd_en, x_rd_addr,
    input  x_rd_data,
    output x_out_valid, x_out_data, x_out_first, x_out_last,
    input  x_out_ready
  );

  modport slave (
    input  x_rd_en, x_rd_addr,
    output x_rd_data,
    input  x_out_valid, x_out_data, x_out_first, x_out_last,
    output x_out_ready
  );
endinterface

// File: rtl/sgd_x_rd.sv
// Credit-gated reader of the model x BRAM. Waits for a group credit from sgd_x_wr, reads all
// chunks of the model in address order and streams them through a skid FIFO with valid/ready.
module sgd_x_rd #(
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned CHUNK_SHIFT  = 6,
  parameter int unsigned NUM_OF_BANKS = 8,
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_started,
  input  logic [31:0]       i_dimension,
  input  logic [31:0]       i_number_of_epochs,
  input  logic [31:0]       i_number_of_samples,
  input  logic [7:0]        i_x_wr_credit_counter,
  sgd_x_rd_if.master        x_if,
  output logic              o_sgd_x_rd_done,
  output logic              o_sgd_x_rd_error,
  output logic [31:0]       o_state_counters_x_rd
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EntW = DATA_WIDTH + 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StEpoch  = 3'd2,
    StWait   = 3'd3,
    StRead   = 3'd4,
    StDrain  = 3'd5,
    StFinish = 3'd6
  } state_e;

  state_e                r_state;
  logic                  r_started_q;
  logic [7:0]            r_credit;
  logic [7:0]            r_consumed;
  logic [31:0]           r_dim, r_samples, r_epochs, r_groups;
  logic [31:0]           r_epoch_idx, r_group_idx;
  logic [11:0]           r_chunks, r_addr;
  logic                  r_done, r_error;
  logic                  r_rd_en, r_rd_first, r_rd_last;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [RD_LATENCY-1:0] r_sr_vld, r_sr_first, r_sr_last;
  logic [EntW-1:0]       r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]       r_count;

  logic [32:0]           w_dim_round;
  logic [11:0]           w_chunks;
  logic [31:0]           w_groups, w_grp_next;
  logic [7:0]            w_avail, w_inflight, w_total;
  logic                  w_has_credit, w_last_chunk, w_push, w_pop, w_room, w_pipe_empty;
  logic [EntW-1:0]       w_head;

  assign w_dim_round  = {1'b0, r_dim} + 33'((1 << CHUNK_SHIFT) - 1);
  assign w_chunks     = 12'(w_dim_round >> CHUNK_SHIFT);
  assign w_groups     = r_samples / 32'(NUM_OF_BANKS);
  assign w_avail      = r_credit - r_consumed;
  assign w_has_credit = (w_avail != 8'd0);
  assign w_last_chunk = (r_addr == r_chunks - 12'd1);
  assign w_grp_next   = r_group_idx + 32'd1;
  assign w_push       = r_sr_vld[RD_LATENCY-1];
  assign w_pop        = (r_count != '0) && x_if.x_out_ready;

  // Occupancy plus outstanding reads as they will stand after this edge; a new strobe is only
  // allowed if that total leaves a free slot, so the FIFO can never overflow.
  always_comb begin
    w_inflight = 8'(r_rd_en);
    for (int i = 0; i < int'(RD_LATENCY) - 1; i++) begin
      w_inflight = w_inflight + 8'(r_sr_vld[i]);
    end
    w_total      = 8'(r_count) + 8'(w_push) - 8'(w_pop) + w_inflight;
    w_room       = (w_total < 8'(FIFO_DEPTH));
    w_pipe_empty = !r_rd_en && (r_sr_vld == '0) && (r_count == '0);
  end

  // Control FSM: credit accounting, epoch/group sequencing and read-strobe issue.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_started_q <= 1'b0;
      r_credit    <= '0;
      r_consumed  <= '0;
      r_dim       <= '0;
      r_samples   <= '0;
      r_epochs    <= '0;
      r_groups    <= '0;
      r_chunks    <= '0;
      r_epoch_idx <= '0;
      r_group_idx <= '0;
      r_addr      <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_first  <= 1'b0;
      r_rd_last   <= 1'b0;
    end else begin
      r_started_q <= i_started;
      r_credit    <= i_x_wr_credit_counter;
      r_rd_en     <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_started && !r_started_q) begin
            r_dim     <= i_dimension;
            r_samples <= i_number_of_samples;
            r_epochs  <= i_number_of_epochs;
            r_state   <= StStart;
          end
        end
        StStart: begin
          r_epoch_idx <= '0;
          r_consumed  <= '0;
          r_done      <= 1'b0;
          r_error     <= 1'b0;
          r_chunks    <= w_chunks;
          r_groups    <= w_groups;
          if (r_dim == '0 || r_samples == '0) begin
            r_error <= 1'b1;
            r_state <= StFinish;
          end else begin
            r_state <= StEpoch;
          end
        end
        StEpoch: begin
          if (r_epoch_idx == r_epochs) begin
            r_state <= StDrain;
          end else begin
            r_group_idx <= '0;
            r_epoch_idx <= r_epoch_idx + 32'd1;
            r_state     <= StWait;
          end
        end
        StWait: begin
          if (r_group_idx == r_groups) begin
            r_state <= StEpoch;
          end else if (w_has_credit) begin
            r_consumed <= r_consumed + 8'd1;
            r_addr     <= '0;
            r_state    <= StRead;
          end
        end
        StRead: begin
          if (w_room) begin
            r_rd_en    <= 1'b1;
            r_rd_addr  <= ADDR_WIDTH'(r_addr);
            r_rd_first <= (r_addr == '0);
            r_rd_last  <= w_last_chunk;
            if (!w_last_chunk) begin
              r_addr <= r_addr + 12'd1;
            end else begin
              r_addr <= '0;
              // Chain straight into the next group when credit allows, avoiding a WAIT bubble.
              if (w_grp_next != r_groups && w_has_credit) begin
                r_group_idx <= w_grp_next;
                r_consumed  <= r_consumed + 8'd1;
              end else if (w_grp_next == r_groups && r_epoch_idx != r_epochs && w_has_credit) begin
                r_group_idx <= '0;
                r_epoch_idx <= r_epoch_idx + 32'd1;
                r_consumed  <= r_consumed + 8'd1;
              end else begin
                r_group_idx <= w_grp_next;
                r_state     <= StWait;
              end
            end
          end
        end
        StDrain: begin
          if (w_pipe_empty) begin
            r_done  <= 1'b1;
            r_state <= StFinish;
          end
        end
        StFinish: begin
          r_state <= StFinish;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Read-latency tracker and FIFO pointers; reset drops every outstanding read.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sr_vld   <= '0;
      r_sr_first <= '0;
      r_sr_last  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_sr_vld[0]   <= r_rd_en;
      r_sr_first[0] <= r_rd_first;
      r_sr_last[0]  <= r_rd_last;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        r_sr_vld[i]   <= r_sr_vld[i-1];
        r_sr_first[i] <= r_sr_first[i-1];
        r_sr_last[i]  <= r_sr_last[i-1];
      end
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PtrW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PtrW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PtrW'(1);
      end
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  // FIFO storage, tagged with first/last; contents need no reset since valid gates the head.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_sr_first[RD_LATENCY-1], r_sr_last[RD_LATENCY-1], x_if.x_rd_data};
    end
  end

  assign w_head                = r_mem[r_rd_ptr];
  assign x_if.x_rd_en          = r_rd_en;
  assign x_if.x_rd_addr        = r_rd_addr;
  assign x_if.x_out_valid      = (r_count != '0);
  assign x_if.x_out_data       = x_if.x_out_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign x_if.x_out_first      = x_if.x_out_valid & w_head[DATA_WIDTH+1];
  assign x_if.x_out_last       = x_if.x_out_valid & w_head[DATA_WIDTH];
  assign o_sgd_x_rd_done       = r_done;
  assign o_sgd_x_rd_error      = r_error;
  assign o_state_counters_x_rd = {r_state, r_consumed, r_group_idx[20:0]};

endmodule

// File: tb/tb_sgd_x_rd.sv
// Self-checking bench for sgd_x_rd: BRAM model with fixed read latency, scoreboard of
// expected chunks pushed at run start and compared against popped output beats.
module tb_sgd_x_rd;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 256;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        started = 1'b0;
  logic [31:0] dimension = '0, epochs = '0, samples = '0;
  logic [7:0]  credit = '0;
  logic        done, error;
  logic [31:0] dbg;

  sgd_x_rd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) xif ();

  sgd_x_rd #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHUNK_SHIFT(6), .NUM_OF_BANKS(8),
    .RD_LATENCY(2), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_started             (started),
    .i_dimension           (dimension),
    .i_number_of_epochs    (epochs),
    .i_number_of_samples   (samples),
    .i_x_wr_credit_counter (credit),
    .x_if                  (xif),
    .o_sgd_x_rd_done       (done),
    .o_sgd_x_rd_error      (error),
    .o_state_counters_x_rd (dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] chunk_val(input logic [AW-1:0] a);
    logic [31:0] w;
    logic [DW-1:0] v;
    w = {23'd0, a} * 32'h9E37_79B1 + 32'h1234_5678;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = w + 32'(k);
    return v;
  endfunction

  // BRAM model: data valid two cycles after the strobe.
  logic [DW-1:0] bram_p1;
  always @(posedge clk) begin
    bram_p1       <= chunk_val(xif.x_rd_addr);
    xif.x_rd_data <= bram_p1;
  end

  typedef logic [DW+1:0] beat_t;
  beat_t           q_exp[$];
  beat_t           q_obs[$];
  logic [AW-1:0]   q_addr[$];
  beat_t           exp_b, obs_b;
  int              n_pass = 0, n_total = 0;
  int              n_iss = 0, n_pop = 0, n_viol = 0;
  bit              rand_ready = 0;
  bit              ok;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) xif.x_out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (xif.x_rd_en) begin
      if (n_iss - n_pop >= int'(DEPTH)) n_viol++;
      q_addr.push_back(xif.x_rd_addr);
      n_iss++;
    end
    if (xif.x_out_valid && xif.x_out_ready) begin
      q_obs.push_back({xif.x_out_first, xif.x_out_last, xif.x_out_data});
      n_pop++;
    end
  endtask

  task automatic clear_sb();
    q_exp.delete(); q_obs.delete(); q_addr.delete();
    n_iss = 0; n_pop = 0; n_viol = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; started = 1'b0; rand_ready = 0; xif.x_out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    clear_sb();
  endtask

  task automatic start_run(input int dim, input int smp, input int ep);
    int ch;
    dimension = 32'(dim); samples = 32'(smp); epochs = 32'(ep);
    ch = (dim + 63) / 64;
    if (dim != 0 && smp != 0)
      for (int e = 0; e < ep; e++)
        for (int g = 0; g < smp / 8; g++)
          for (int c = 0; c < ch; c++)
            q_exp.push_back({c == 0, c == ch - 1, chunk_val(AW'(c))});
    tick();
    started = 1'b1;
  endtask

  task automatic run_until_done(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin got = 1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (dbg !== 32'h0) $display("FAIL reset_dbg: got %0h want 0", dbg); else n_pass++;
    n_total++; if (done !== 1'b0 || error !== 1'b0)
      $display("FAIL reset_flags: got done=%b err=%b want 0 0", done, error); else n_pass++;
    n_total++; if (xif.x_rd_en !== 1'b0 || xif.x_out_valid !== 1'b0 || xif.x_out_data !== '0)
      $display("FAIL reset_bus: got en=%b vld=%b want 0 0", xif.x_rd_en, xif.x_out_valid);
    else n_pass++;
  endtask

  task automatic test_credit_step();
    logic [AW-1:0] a;
    do_reset();
    credit = 8'd0;
    start_run(128, 16, 1);
    repeat (20) tick();
    n_total++; if (n_iss != 0) $display("FAIL t1_no_issue: got %0d reads want 0", n_iss);
    else n_pass++;
    n_total++; if (dbg[31:29] !== 3'd3) $display("FAIL t1_wait: got state %0d want 3", dbg[31:29]);
    else n_pass++;
    credit = 8'd2;
    run_until_done(200, ok);
    n_total++; if (!ok) $display("FAIL t1_done: got timeout want done"); else n_pass++;
    n_total++; if (n_pop != 4) $display("FAIL t1_pops_at_done: got %0d want 4", n_pop); else n_pass++;
    n_total++; if (q_addr.size() != 4) $display("FAIL t1_naddr: got %0d want 4", q_addr.size());
    else n_pass++;
    for (int i = 0; i < 4 && q_addr.size() != 0; i++) begin
      a = q_addr.pop_front();
      n_total++; if (a !== AW'(i % 2)) $display("FAIL t1_addr%0d: got %0d want %0d", i, a, i % 2);
      else n_pass++;
    end
    n_total++; if (q_obs.size() != q_exp.size())
      $display("FAIL t1_nbeats: got %0d want %0d", q_obs.size(), q_exp.size()); else n_pass++;
    while (q_exp.size() != 0 && q_obs.size() != 0) begin
      exp_b = q_exp.pop_front(); obs_b = q_obs.pop_front();
      n_total++; if (obs_b !== exp_b) $display("FAIL t1_beat: got %0h want %0h", obs_b, exp_b);
      else n_pass++;
    end
    n_total++; if (dbg[28:21] !== 8'd2) $display("FAIL t1_consumed: got %0d want 2", dbg[28:21]);
    else n_pass++;
  endtask

  task automatic test_credit_stall();
    do_reset();
    credit = 8'd1;
    start_run(128, 32, 1);
    repeat (40) tick();
    n_total++; if (n_pop != 2) $display("FAIL t2_one_group: got %0d beats want 2", n_pop); else n_pass++;
    n_total++; if (dbg[31:29] !== 3'd3) $display("FAIL t2_wait: got state %0d want 3", dbg[31:29]);
    else n_pass++;
    n_total++; if (dbg[28:21] !== 8'd1) $display("FAIL t2_consumed: got %0d want 1", dbg[28:21]);
    else n_pass++;
    credit = 8'd4;
    run_until_done(200, ok);
    n_total++; if (!ok) $display("FAIL t2_done: got timeout want done"); else n_pass++;
    n_total++; if (q_obs.size() != q_exp.size())
      $display("FAIL t2_nbeats: got %0d want %0d", q_obs.size(), q_exp.size()); else n_pass++;
    while (q_exp.size() != 0 && q_obs.size() != 0) begin
      exp_b = q_exp.pop_front(); obs_b = q_obs.pop_front();
      n_total++; if (obs_b !== exp_b) $display("FAIL t2_beat: got %0h want %0h", obs_b, exp_b);
      else n_pass++;
    end
  endtask

  task automatic test_random_ready();
    do_reset();
    credit = 8'd9;
    rand_ready = 1;
    start_run(300, 24, 3);
    run_until_done(3000, ok);
    rand_ready = 0; xif.x_out_ready = 1'b1;
    n_total++; if (!ok) $display("FAIL t3_done: got timeout want done"); else n_pass++;
    n_total++; if (q_obs.size() != 45) $display("FAIL t3_nbeats: got %0d want 45", q_obs.size());
    else n_pass++;
    n_total++; if (n_viol != 0) $display("FAIL t3_fifo_rule: got %0d violations want 0", n_viol);
    else n_pass++;
    while (q_exp.size() != 0 && q_obs.size() != 0) begin
      exp_b = q_exp.pop_front(); obs_b = q_obs.pop_front();
      n_total++; if (obs_b !== exp_b) $display("FAIL t3_beat: got %0h want %0h", obs_b, exp_b);
      else n_pass++;
    end
  endtask

  task automatic test_credit_wrap();
    do_reset();
    credit = 8'd254;
    start_run(64, 8 * 258, 1);
    for (int i = 0; i < 2000 && !(n_pop == 254 && dbg[31:29] == 3'd3); i++) tick();
    repeat (5) tick();
    n_total++; if (dbg[28:21] !== 8'd254) $display("FAIL t4_consumed: got %0d want 254", dbg[28:21]);
    else n_pass++;
    n_total++; if (n_pop != 254) $display("FAIL t4_pre_wrap: got %0d beats want 254", n_pop);
    else n_pass++;
    credit = 8'd2;
    run_until_done(200, ok);
    n_total++; if (!ok) $display("FAIL t4_done: got timeout want done"); else n_pass++;
    n_total++; if (dbg[28:21] !== 8'd2) $display("FAIL t4_wrapped: got %0d want 2", dbg[28:21]);
    else n_pass++;
    n_total++; if (q_obs.size() != q_exp.size())
      $display("FAIL t4_nbeats: got %0d want %0d", q_obs.size(), q_exp.size()); else n_pass++;
    while (q_exp.size() != 0 && q_obs.size() != 0) begin
      exp_b = q_exp.pop_front(); obs_b = q_obs.pop_front();
      n_total++; if (obs_b !== exp_b) $display("FAIL t4_beat: got %0h want %0h", obs_b, exp_b);
      else n_pass++;
    end
  endtask

  task automatic test_config_edges();
    do_reset();
    credit = 8'd5;
    start_run(0, 16, 1);
    repeat (20) tick();
    n_total++; if (error !== 1'b1) $display("FAIL t5_error: got %b want 1", error); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL t5_err_done: got %b want 0", done); else n_pass++;
    n_total++; if (n_iss != 0) $display("FAIL t5_err_reads: got %0d want 0", n_iss); else n_pass++;
    do_reset();
    start_run(128, 16, 0);
    run_until_done(50, ok);
    n_total++; if (!ok) $display("FAIL t5_ep0_done: got timeout want done"); else n_pass++;
    n_total++; if (error !== 1'b0) $display("FAIL t5_ep0_error: got %b want 0", error); else n_pass++;
    n_total++; if (n_iss != 0) $display("FAIL t5_ep0_reads: got %0d want 0", n_iss); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    credit = 8'd4;
    start_run(300, 8, 1);
    for (int i = 0; i < 50 && n_iss < 2; i++) tick();
    n_total++; if (n_iss != 2) $display("FAIL t6_inflight: got %0d reads want 2", n_iss); else n_pass++;
    rst_n = 1'b0; started = 1'b0;
    tick();
    n_total++; if (dbg !== 32'h0 || done !== 1'b0 || error !== 1'b0)
      $display("FAIL t6_rst_regs: got dbg=%0h done=%b err=%b want 0", dbg, done, error); else n_pass++;
    n_total++; if (xif.x_rd_en !== 1'b0 || xif.x_out_valid !== 1'b0 || xif.x_out_first !== 1'b0 ||
                   xif.x_out_last !== 1'b0 || xif.x_out_data !== '0 || xif.x_rd_addr !== '0)
      $display("FAIL t6_rst_bus: got en=%b vld=%b addr=%0d want 0", xif.x_rd_en, xif.x_out_valid,
               xif.x_rd_addr);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    clear_sb();
    start_run(300, 8, 1);
    run_until_done(200, ok);
    n_total++; if (!ok) $display("FAIL t6_done: got timeout want done"); else n_pass++;
    n_total++; if (q_addr.size() == 0 || q_addr[0] !== '0)
      $display("FAIL t6_replay_addr: got %0d strobes want first addr 0", q_addr.size()); else n_pass++;
    n_total++; if (dbg[28:21] !== 8'd1) $display("FAIL t6_consumed: got %0d want 1", dbg[28:21]);
    else n_pass++;
    n_total++; if (q_obs.size() != q_exp.size())
      $display("FAIL t6_nbeats: got %0d want %0d", q_obs.size(), q_exp.size()); else n_pass++;
    while (q_exp.size() != 0 && q_obs.size() != 0) begin
      exp_b = q_exp.pop_front(); obs_b = q_obs.pop_front();
      n_total++; if (obs_b !== exp_b) $display("FAIL t6_beat: got %0h want %0h", obs_b, exp_b);
      else n_pass++;
    end
  endtask

  initial begin
    xif.x_out_ready = 1'b1;
    test_reset();
    test_credit_step();
    test_credit_stall();
    test_random_ready();
    test_credit_wrap();
    test_config_edges();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sgd_x_rd.md
Name: sgd_x_rd

Overview:
Credit-gated reader of the model x BRAM. It is the consumer side of the x_wr_credit_counter handshake that sgd_x_wr drives. For every group of NUM_OF_BANKS samples it waits for a credit, then reads all x chunks of the model in address order. It streams the chunks to the dot-product (ax) pipeline with valid/ready backpressure, so the ax module only ever reads model versions that sgd_x_wr has already committed.

Parameters:
ADDR_WIDTH, 9, x BRAM address width (matches `X_BIT_DEPTH).
DATA_WIDTH, 256, x chunk width (`NUM_BITS_PER_BANK*32).
CHUNK_SHIFT, 6, log2 of features per chunk (`BIT_WIDTH_OF_BANK+`ENGINE_NUM_WIDTH).
NUM_OF_BANKS, 8, samples consumed per group.
RD_LATENCY, 2, fixed BRAM read latency in cycles (1..3).
FIFO_DEPTH, 4, output skid FIFO depth; must be at least RD_LATENCY+1.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
started  in  1  level; run begins on its rising edge
dimension  in  32  feature count
number_of_epochs  in  32  epochs to run
number_of_samples  in  32  samples per epoch; a multiple of NUM_OF_BANKS
x_wr_credit_counter  in  8  cumulative group credits from sgd_x_wr; wraps mod 256
x_rd_en  out  1  BRAM read strobe
x_rd_addr  out  ADDR_WIDTH  chunk address
x_rd_data  in  DATA_WIDTH  BRAM data, valid RD_LATENCY cycles after x_rd_en
x_out_valid  out  1  chunk valid to ax
x_out_ready  in  1  ax accepts chunk
x_out_data  out  DATA_WIDTH  chunk payload
x_out_first  out  1  chunk 0 of a group
x_out_last  out  1  final chunk of a group
sgd_x_rd_done  out  1  all epochs issued and drained; sticky
sgd_x_rd_error  out  1  configuration error; sticky
state_counters_x_rd  out  32  debug word: {state[2:0], consumed[7:0], group_index[20:0]}

Behaviour:
- Reset: every output is 0, the FIFO is empty, state is IDLE, and the consumed counter is 0. Reset mid-run aborts immediately and drops in-flight reads.
- Config registers are sampled one cycle after started rises. Derived values:
  - chunks = ceil(dimension / 2^CHUNK_SHIFT), 12-bit.
  - groups_per_epoch = number_of_samples / NUM_OF_BANKS.
- Credit check: avail = (x_wr_credit_counter − consumed) mod 256. A group may start only when avail != 0. consumed increments by 1 when a group starts.
- Read issue: x_rd_en=1 only when occupancy + in_flight < FIFO_DEPTH. The address counts 0 .. chunks−1 within each group.
- Read return: data is pushed into the FIFO exactly RD_LATENCY cycles after the strobe, tagged with its first/last flags.
- Output: FIFO head drives x_out_*. A pop happens on x_out_valid & x_out_ready. Ordering is strict, and no chunk is lost or duplicated under any ready pattern.
- FSM:
  - IDLE: on started rising edge go to START.
  - START: clear epoch_index, consumed, done and error. If dimension==0 or number_of_samples==0, set error=1 and go to FINISH. Otherwise go to EPOCH.
  - EPOCH: if epoch_index == number_of_epochs go to DRAIN. Otherwise clear group_index, increment epoch_index, and go to WAIT.
  - WAIT: if group_index == groups_per_epoch go to EPOCH. Otherwise, when avail != 0, increment consumed and go to READ.
  - READ: issue chunks under the FIFO rule. After the strobe for chunk chunks−1, increment group_index and go to WAIT. The next group may be issued while the previous one is still draining.
  - DRAIN: wait until FIFO and in-flight are both empty, then go to FINISH.
  - FINISH: sgd_x_rd_done=1 (no done assertion if the error path was taken). Hold until reset.
- number_of_epochs == 0: go straight to DRAIN, then FINISH, with no reads.
- chunks == 1: x_out_first and x_out_last are both 1 on the same beat.
- Credit arriving in the same cycle as the check: it is seen only via the registered input, so at most 1 cycle of extra stall.
- Throughput: with ready held high and credit available, 1 chunk per cycle, with no bubbles between groups.

Test Plan:
1. dimension=128, samples=16, epochs=1, credit stepped 0→2 at cycle 20 → nothing issued before the credit step. Then 2 groups of 2 chunks (addr 0,1,0,1) with first/last flags correct. Done asserts after the last pop.
2. Credit held at 1, samples=32 → exactly 1 group is output, and the block stalls in WAIT with consumed=1. Raising credit to 4 → the remaining 3 groups stream out.
3. Random x_out_ready (50%), dimension=300 (5 chunks), 3 epochs, samples=24 → 45 beats in strict order, none dropped or duplicated. x_rd_en never fires while the FIFO plus in-flight count is at FIFO_DEPTH.
4. Credit wrap: consumed=254, credit steps 254→2 (mod 256) → 4 groups issued correctly across the wrap.
5. dimension=0 → error=1, no x_rd_en, done=0. epochs=0 → done=1, no reads.
6. Assert reset mid-READ with 2 reads in flight → the next cycle has all outputs 0. A fresh run after reset replays from addr 0 with consumed=0.
